linefill_buffer_cwf: RTL



---
 rtl/linefill_buffer_cwf.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/linefill_buffer_cwf.sv
// ---------------------------------------------------------------------------
// linefill_buffer_cwf
//
// Cache line-fill buffer between the data cache controller and the cache-side
// AXI master. An accepted miss request launches one burst read. The beats are
// assembled into a full line of WORDS_PER_LINE words. The requested (critical)
// word is reported as soon as it arrives.
//
// WRAP_MODE=1 : the burst starts at the requested word and wraps around the
//               line, so the critical word is always the first beat.
// WRAP_MODE=0 : the burst starts at the line base address.
//
// An in-flight fill can be aborted. The burst already launched on the bus
// must still be consumed, so its remaining beats are drained and discarded.
//
// Ports:
//   Clk, Rst           clock, asynchronous active-high reset
//   Enable, Address    fill request and miss byte address (sampled in IDLE)
//   Abort              cancel the current fill (START/FILL only)
//   RequestAttended    beat valid from the AXI master, with Data
//   AXIStartRead       one-cycle burst start strobe, with AXIAddr
//   BaseAddress        line-aligned address of the current/last line
//   Line, WordValid    assembled line and per-word written flags
//   CriticalWord       word at the requested offset
//   FirstDataAcquired  one-cycle pulse after the critical word is written
//   LineReadCompleted  one-cycle pulse after the last beat is written
//   Busy               high in any state other than IDLE
// ---------------------------------------------------------------------------
module linefill_buffer_cwf #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int WRAP_MODE      = 1
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 Enable,
  input  logic [ADDR_WIDTH-1:0]                Address,
  input  logic                                 Abort,
  input  logic                                 RequestAttended,
  input  logic [DATA_WIDTH-1:0]                Data,
  output logic                                 AXIStartRead,
  output logic [ADDR_WIDTH-1:0]                AXIAddr,
  output logic [ADDR_WIDTH-1:0]                BaseAddress,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] Line,
  output logic [WORDS_PER_LINE-1:0]            WordValid,
  output logic [DATA_WIDTH-1:0]                CriticalWord,
  output logic                                 FirstDataAcquired,
  output logic                                 LineReadCompleted,
  output logic                                 Busy
);

  // Byte-offset bits within a word, and word-index bits within a line.
  localparam int BW = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int LW = DATA_WIDTH * WORDS_PER_LINE;

  // Masks that clear the byte offset (word aligned) or the whole line offset.
  // Built with shifts so that BW=0 (byte-wide words) still works.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    ~((ADDR_WIDTH'(1) << BW) - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << (BW + IW)) - ADDR_WIDTH'(1));

  localparam logic [IW-1:0] LAST_BEAT = IW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_FILL,
    ST_DRAIN
  } state_t;

  state_t                  state_q,      state_d;
  logic [ADDR_WIDTH-1:0]   base_addr_q,  base_addr_d;
  logic [ADDR_WIDTH-1:0]   axi_addr_q,   axi_addr_d;
  logic [IW-1:0]           offset_q,     offset_d;
  logic [IW-1:0]           index_q,      index_d;
  logic [IW-1:0]           count_q,      count_d;
  logic [LW-1:0]           line_q,       line_d;
  logic [WORDS_PER_LINE-1:0] word_valid_q, word_valid_d;
  logic [DATA_WIDTH-1:0]   critical_q,   critical_d;
  logic                    first_q,      first_d;
  logic                    done_q,       done_d;

  logic [IW-1:0]           req_offset;
  logic                    last_beat;

  assign req_offset = Address[BW +: IW];

  // The beat counter counts every beat of the burst, including beats
  // received before an abort, so the drain knows how many are still owed.
  assign last_beat = (count_q == LAST_BEAT);

  // Next-state and datapath logic. The two pulse outputs default to zero so
  // they can only ever last a single cycle.
  always_comb begin
    state_d      = state_q;
    base_addr_d  = base_addr_q;
    axi_addr_d   = axi_addr_q;
    offset_d     = offset_q;
    index_d      = index_q;
    count_d      = count_q;
    line_d       = line_q;
    word_valid_d = word_valid_q;
    critical_d   = critical_q;
    first_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Beats arriving while idle do not belong to any burst and are ignored.
        if (Enable) begin
          base_addr_d  = Address & LINE_MASK;
          axi_addr_d   = (WRAP_MODE != 0) ? (Address & WORD_MASK)
                                          : (Address & LINE_MASK);
          offset_d     = req_offset;
          word_valid_d = '0;
          state_d      = ST_START;
        end
      end

      ST_START: begin
        // Wrap bursts deliver the requested word first, so writing starts
        // at that slot; incrementing bursts start at slot 0.
        index_d = (WRAP_MODE != 0) ? offset_q : '0;
        count_d = '0;
        if (Abort) begin
          word_valid_d = '0;
          state_d      = ST_DRAIN;
        end else begin
          state_d      = ST_FILL;
        end
      end

      ST_FILL: begin
        if (Abort) begin
          // A beat arriving in the abort cycle is counted but discarded.
          // If it was the last beat, nothing remains to drain.
          word_valid_d = '0;
          if (RequestAttended) begin
            count_d = count_q + 1'b1;
            state_d = last_beat ? ST_IDLE : ST_DRAIN;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (RequestAttended) begin
          for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (index_q == IW'(w)) begin
              line_d[w*DATA_WIDTH +: DATA_WIDTH] = Data;
            end
          end
          word_valid_d[index_q] = 1'b1;
          if (index_q == offset_q) begin
            critical_d = Data;
            first_d    = 1'b1;
          end
          // The index is exactly IW bits wide, so it wraps modulo the line size.
          index_d = index_q + 1'b1;
          count_d = count_q + 1'b1;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        // Swallow the rest of the aborted burst without touching the line.
        if (RequestAttended) begin
          count_d = count_q + 1'b1;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset discards any fill in progress immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      base_addr_q  <= '0;
      axi_addr_q   <= '0;
      offset_q     <= '0;
      index_q      <= '0;
      count_q      <= '0;
      line_q       <= '0;
      word_valid_q <= '0;
      critical_q   <= '0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_addr_q  <= base_addr_d;
      axi_addr_q   <= axi_addr_d;
      offset_q     <= offset_d;
      index_q      <= index_d;
      count_q      <= count_d;
      line_q       <= line_d;
      word_valid_q <= word_valid_d;
      critical_q   <= critical_d;
      first_q      <= first_d;
      done_q       <= done_d;
    end
  end

  assign AXIStartRead      = (state_q == ST_START);
  assign Busy              = (state_q != ST_IDLE);
  assign AXIAddr           = axi_addr_q;
  assign BaseAddress       = base_addr_q;
  assign Line              = line_q;
  assign WordValid         = word_valid_q;
  assign CriticalWord      = critical_q;
  assign FirstDataAcquired = first_q;
  assign LineReadCompleted = done_q;

endmodule
